mac_dot_sequencer: RTL and testbench

MAC_DOT_SEQUENCER -- requirements
Module: mac_dot_sequencer

---
 rtl/mac_dot_sequencer.sv | 145 ++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer.sv
// Job sequencer for a 2-stage MAC: clears the accumulator, streams operand
// pairs into it, waits out the pipeline and holds the dot-product result.
module mac_dot_sequencer #(
    parameter  int W_WIDTH    = 8,
    parameter  int A_WIDTH    = 8,
    parameter  int PLUS_WIDTH = 4,
    parameter  int LEN_WIDTH  = 8,
    localparam int Z_WIDTH    = W_WIDTH + A_WIDTH + PLUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 abort,
    output logic                 busy,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [W_WIDTH-1:0]   op_w,
    input  logic [A_WIDTH-1:0]   op_a,
    output logic [W_WIDTH-1:0]   mac_w,
    output logic [A_WIDTH-1:0]   mac_a,
    output logic                 mac_accu_rst,
    input  logic [Z_WIDTH-1:0]   mac_z,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [Z_WIDTH-1:0]   res_z,
    output logic [LEN_WIDTH-1:0] res_len
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] cnt_inc;
    logic                 drain_q, drain_d;
    logic [Z_WIDTH-1:0]   res_z_q, res_z_d;
    logic [LEN_WIDTH-1:0] res_len_q, res_len_d;
    logic                 xfer;
    logic                 ready_int;
    logic                 accu_rst_int;

    assign cnt_inc = cnt_q + LEN_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            drain_q   <= 1'b0;
            res_z_q   <= '0;
            res_len_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            res_z_q   <= res_z_d;
            res_len_q <= res_len_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        drain_d      = drain_q;
        res_z_d      = res_z_q;
        res_len_d    = res_len_q;
        ready_int    = 1'b0;
        accu_rst_int = 1'b0;
        xfer         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                accu_rst_int = 1'b1;
                drain_d      = 1'b0;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (len_q != '0) begin
                    state_d = S_FEED;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_FEED: begin
                ready_int = 1'b1;
                xfer      = op_valid;
                if (xfer) begin
                    cnt_d = cnt_inc;
                end
                // abort wins; a same-cycle operand is consumed but dropped
                if (abort) begin
                    accu_rst_int = 1'b1;
                    state_d      = S_IDLE;
                end else if (xfer && (cnt_inc == len_q)) begin
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (abort) begin
                    accu_rst_int = 1'b1;
                    state_d      = S_IDLE;
                end else if (drain_q) begin
                    res_z_d   = mac_z;
                    res_len_d = len_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // outputs go quiet during the reset cycle itself, not only after it
    assign busy         = (state_q != S_IDLE) && !rst;
    assign op_ready     = ready_int && !rst;
    assign mac_accu_rst = accu_rst_int && !rst;
    assign res_valid    = (state_q == S_DONE) && !rst;
    assign mac_w        = (xfer && !rst) ? op_w : '0;
    assign mac_a        = (xfer && !rst) ? op_a : '0;
    assign res_z        = res_z_q;
    assign res_len      = res_len_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a behavioural 2-stage MAC and a
// queue-based scoreboard that checks every result handshake.
module tb_mac_dot_sequencer;

    localparam int W = 8;
    localparam int A = 8;
    localparam int P = 4;
    localparam int L = 8;
    localparam int Z = W + A + P;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [L-1:0] len;
    logic         abort;
    logic         busy;
    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] op_w;
    logic [A-1:0] op_a;
    logic [W-1:0] mac_w;
    logic [A-1:0] mac_a;
    logic         mac_accu_rst;
    logic [Z-1:0] mac_z;
    logic         res_valid;
    logic         res_ready;
    logic [Z-1:0] res_z;
    logic [L-1:0] res_len;

    mac_dot_sequencer #(
        .W_WIDTH(W), .A_WIDTH(A), .PLUS_WIDTH(P), .LEN_WIDTH(L)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .abort(abort), .busy(busy),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_w(op_w), .op_a(op_a),
        .mac_w(mac_w), .mac_a(mac_a), .mac_accu_rst(mac_accu_rst),
        .mac_z(mac_z),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_z(res_z), .res_len(res_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [Z-1:0] ws, as_, prod_q, acc_q;
    assign ws    = Z'(signed'(mac_w));
    assign as_   = Z'(mac_a);
    assign mac_z = acc_q;
    always @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= ws * as_;
            acc_q  <= mac_accu_rst ? '0 : acc_q + prod_q;
        end
    end

    typedef struct {
        logic [Z-1:0] z;
        logic [L-1:0] l;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 32'(res_z), 32'hDEAD);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("res_z", 32'(res_z), 32'(e.z));
                chk("res_len", 32'(res_len), 32'(e.l));
            end
        end
    end

    logic signed [W-1:0] wv[16];
    logic        [A-1:0] av[16];

    task automatic run_job(input int n, input logic [15:0] pat,
                           input int plen, input int exp_z,
                           input int abort_at, input bit stall);
        int s, t, k, pi, lat;
        bit ok_rdy, ok_zero, aborted, got;
        if (stall) res_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        len   = L'(n);
        s     = cyc;
        if (abort_at < 0) sb_q.push_back('{z: Z'(exp_z), l: L'(n)});
        @(posedge clk); #1;
        start    = 1'b0;
        op_valid = 1'b1;
        op_w     = 8'h07;
        op_a     = 8'h09;
        @(negedge clk);
        chk("clear_op_ready", 32'(op_ready), 0);
        chk("clear_accu_rst", 32'(mac_accu_rst), 1);
        chk("clear_mac_w", 32'(mac_w), 0);
        k = 0; pi = 0; t = s + 1;
        ok_rdy = 1'b1; ok_zero = 1'b1; aborted = 1'b0;
        while (k < n && !aborted) begin
            @(posedge clk); #1;
            op_valid = (pi < plen) ? pat[pi] : 1'b1;
            op_w     = wv[k];
            op_a     = av[k];
            pi++;
            if (k == abort_at) abort = 1'b1;
            @(negedge clk);
            if (!op_ready) ok_rdy = 1'b0;
            if (abort) begin
                chk("abort_accu_rst", 32'(mac_accu_rst), 1);
                @(posedge clk); #1;
                abort    = 1'b0;
                op_valid = 1'b0;
                @(negedge clk);
                chk("abort_busy", 32'(busy), 0);
                aborted = 1'b1;
            end else if (op_valid) begin
                k++;
                t = cyc;
            end else if (mac_w != 0 || mac_a != 0) begin
                ok_zero = 1'b0;
            end
            if (cyc - s > 200) begin
                chk("feed_timeout", 32'(k), 32'(n));
                aborted = 1'b1;
            end
        end
        if (n > 0) chk("feed_op_ready", 32'(ok_rdy), 1);
        if (plen > 0) chk("bubble_mac_zero", 32'(ok_zero), 1);
        if (aborted) return;
        got = 1'b0;
        ok_rdy = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            op_valid = 1'b1;
            @(negedge clk);
            if (op_ready) ok_rdy = 1'b0;
            if (res_valid) got = 1'b1;
        end
        op_valid = 1'b0;
        lat = cyc - t;
        chk("drain_op_ready", 32'(ok_rdy), 1);
        chk("res_latency", got ? 32'(lat) : 32'hFFFF, 3);
        if (!got) return;
        if (stall) begin
            for (int i = 0; i < 5; i++) begin
                chk("stall_valid", 32'(res_valid), 1);
                chk("stall_z", 32'(res_z), 32'(Z'(exp_z)));
                @(posedge clk); #1;
                start = (i == 2);
                len   = 8'd3;
                @(negedge clk);
            end
            @(posedge clk); #1;
            start     = 1'b0;
            res_ready = 1'b1;
            @(negedge clk);
            chk("stall_end_valid", 32'(res_valid), 1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_after_hs", 32'(busy), 0);
        chk("idle_valid", 32'(res_valid), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
        op_valid = 1'b1; op_w = 8'h55; op_a = 8'hAA; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_op_ready", 32'(op_ready), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_accu_rst", 32'(mac_accu_rst), 0);
        chk("rst_mac_wa", 32'({mac_w, mac_a}), 0);
        chk("rst_res", 32'({res_z, res_len}), 0);
        @(posedge clk); #1;
        rst = 1'b0; op_valid = 1'b0;

        wv[0] = 1;  wv[1] = -2; wv[2] = 3;  wv[3] = 4;
        av[0] = 10; av[1] = 20; av[2] = 30; av[3] = 255;
        run_job(4, 16'h0000, 0, 1080, -1, 1'b0);
        run_job(4, 16'h0069, 7, 1080, -1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            wv[i] = -128;
            av[i] = 255;
        end
        run_job(16, 16'h0000, 0, -522240, -1, 1'b0);
        run_job(0, 16'h0000, 0, 0, -1, 1'b0);

        wv[0] = 2; wv[1] = 3; av[0] = 4; av[1] = 5;
        run_job(2, 16'h0000, 0, 23, -1, 1'b1);

        wv[0] = 1;  wv[1] = -2; wv[2] = 3;  wv[3] = 4;
        av[0] = 10; av[1] = 20; av[2] = 30; av[3] = 255;
        run_job(4, 16'h0000, 0, 0, 2, 1'b0);
        wv[0] = 5; wv[1] = -1; av[0] = 3; av[1] = 7;
        run_job(2, 16'h0000, 0, 8, -1, 1'b0);

        @(posedge clk); #1;
        start = 1'b1; len = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b1; op_w = 8'd3; op_a = 8'd3;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        chk("drain_busy", 32'(busy), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_flags",
            32'({op_ready, res_valid, mac_accu_rst}), 0);
        chk("mid_rst_mac", 32'({mac_w, mac_a}), 0);
        chk("mid_rst_res", 32'({res_z, res_len}), 0);

        wv[0] = -1; av[0] = 1;
        run_job(1, 16'h0000, 0, -1, -1, 1'b0);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
